ay_regs_multi: RTL and testbench

// Parametrised AY-3-891x register file for 1..4 PSG instances on one CPU

---
 rtl/ay_regs_multi_pkg.sv | 22 ++
 rtl/ay_regs_multi_if.sv | 11 +
 rtl/ay_regs_multi_bank.sv | 53 +++++
 rtl/ay_regs_multi.sv | 93 +++++++++
 tb/tb_ay_regs_multi.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ay_regs_multi_pkg.sv
// Shared constants and helpers for the AY-3-891x register file.
// Register indices, chip-select prefix and the per-register write mask.
package ay_pkg;

  typedef logic [3:0] ay_addr_t;

  localparam ay_addr_t AY_R_MIXER     = 4'd7;
  localparam ay_addr_t AY_R_ENV_SHAPE = 4'd13;
  localparam ay_addr_t AY_R_IOA       = 4'd14;
  localparam ay_addr_t AY_R_IOB       = 4'd15;

  localparam logic [5:0] AY_CHIPSEL_PREFIX = 6'h3F;

  function automatic logic [7:0] reg_mask(input ay_addr_t idx);
    case (idx)
      4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
      default:                 reg_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ay_regs_multi_if.sv
// CPU-side register port of the PSG: address/data select, write and read strobes.
interface ay_regs_multi_if;
  logic       a0;
  logic       wr_tick;
  logic [7:0] wdata;
  logic       rd_tick;
  logic [7:0] rdata;

  modport master (output a0, output wr_tick, output wdata, output rd_tick, input rdata);
  modport slave  (input a0, input wr_tick, input wdata, input rd_tick, output rdata);
endinterface

// File: rtl/ay_regs_multi_bank.sv
// One PSG register bank: 16x8 storage with write masking, R13 restart strobe
// and the I/O-port readback multiplexer.
module ay_reg_bank
  import ay_pkg::*;
#(
  parameter bit MASK_UNUSED = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         we_i,
  input  ay_addr_t     addr_i,
  input  logic [7:0]   wdata_i,
  input  logic [15:0]  io_in_i,
  output logic [127:0] regs_o,
  output logic [15:0]  io_out_o,
  output logic [1:0]   io_oe_o,
  output logic [7:0]   rd_val_o,
  output logic         env_restart_o
);

  logic [7:0] mem_q [16];
  logic       env_q;
  logic [7:0] wmask;

  always_comb wmask = MASK_UNUSED ? reg_mask(addr_i) : 8'hFF;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < 16; i++) mem_q[i] <= '0;
      env_q <= 1'b0;
    end else begin
      env_q <= we_i && (addr_i == AY_R_ENV_SHAPE);
      if (we_i) mem_q[addr_i] <= wdata_i & wmask;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < 16; i++) regs_o[i*8 +: 8] = mem_q[i];
  end

  // R7[6]/R7[7] set the port direction; input ports read back the pins.
  always_comb begin
    rd_val_o = mem_q[addr_i];
    if (addr_i == AY_R_IOA && !mem_q[AY_R_MIXER][6]) rd_val_o = io_in_i[7:0];
    if (addr_i == AY_R_IOB && !mem_q[AY_R_MIXER][7]) rd_val_o = io_in_i[15:8];
  end

  assign io_out_o      = {mem_q[AY_R_IOB], mem_q[AY_R_IOA]};
  assign io_oe_o       = {mem_q[AY_R_MIXER][7], mem_q[AY_R_MIXER][6]};
  assign env_restart_o = env_q;

endmodule

// File: rtl/ay_regs_multi.sv
// Multi-chip AY-3-891x register file: address/chip-select latch, per-chip
// banks and the registered CPU read path.
module ay_regs_multi
  import ay_pkg::*;
#(
  parameter int unsigned NUM_CHIPS   = 1,
  parameter bit          MASK_UNUSED = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  ay_regs_multi_if.slave             bus,
  output logic [NUM_CHIPS*128-1:0]   regs,
  output logic [NUM_CHIPS*16-1:0]    io_out,
  output logic [NUM_CHIPS*2-1:0]     io_oe,
  input  logic [NUM_CHIPS*16-1:0]    io_in,
  output logic [NUM_CHIPS-1:0]       env_restart
);

  localparam logic [2:0] NCH = 3'(NUM_CHIPS);

  logic [1:0] chip_q, chip_d;
  ay_addr_t   addr_q, addr_d;
  logic       valid_q, valid_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] sel_idx;
  logic [7:0] sel_rd;
  logic       data_wr;
  logic [7:0] bank_rd [NUM_CHIPS];

  assign data_wr = bus.wr_tick && bus.a0 && valid_q;

  for (genvar c = 0; c < NUM_CHIPS; c++) begin : g_bank
    ay_reg_bank #(.MASK_UNUSED(MASK_UNUSED)) u_bank (
      .clk_i         (clk),
      .reset_i       (reset),
      .we_i          (data_wr && (chip_q == 2'(c))),
      .addr_i        (addr_q),
      .wdata_i       (bus.wdata),
      .io_in_i       (io_in[c*16 +: 16]),
      .regs_o        (regs[c*128 +: 128]),
      .io_out_o      (io_out[c*16 +: 16]),
      .io_oe_o       (io_oe[c*2 +: 2]),
      .rd_val_o      (bank_rd[c]),
      .env_restart_o (env_restart[c])
    );
  end

  always_comb begin
    sel_rd = '0;
    for (int unsigned c = 0; c < NUM_CHIPS; c++)
      if (chip_q == 2'(c)) sel_rd = bank_rd[c];
  end

  // A chip-select byte leaves the register address and its validity untouched.
  always_comb begin
    chip_d  = chip_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    sel_idx = ~bus.wdata[1:0];
    if (bus.wr_tick && !bus.a0) begin
      if (bus.wdata[7:2] == AY_CHIPSEL_PREFIX) begin
        if ({1'b0, sel_idx} < NCH) chip_d = sel_idx;
      end else if (bus.wdata[7:4] == 4'h0) begin
        addr_d  = bus.wdata[3:0];
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (bus.rd_tick && !bus.wr_tick) begin
      if (bus.a0) rdata_d = valid_q ? sel_rd : 8'hFF;
      else        rdata_d = {chip_q, valid_q, 1'b0, addr_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chip_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      chip_q  <= chip_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ay_regs_multi.sv
// Drives a 2-chip masked instance and a 1-chip unmasked instance in lockstep
// and compares both against an array-based register-file model.
module tb_ay_regs_multi;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ay_regs_multi_if bus0 ();
  ay_regs_multi_if bus1 ();

  logic [255:0] regs0;
  logic [127:0] regs1;
  logic [31:0]  io_out0, io_in0;
  logic [15:0]  io_out1, io_in1;
  logic [3:0]   io_oe0;
  logic [1:0]   io_oe1;
  logic [1:0]   env0;
  logic [0:0]   env1;

  ay_regs_multi #(.NUM_CHIPS(2), .MASK_UNUSED(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .regs(regs0), .io_out(io_out0),
    .io_oe(io_oe0), .io_in(io_in0), .env_restart(env0));

  ay_regs_multi #(.NUM_CHIPS(1), .MASK_UNUSED(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .regs(regs1), .io_out(io_out1),
    .io_oe(io_oe1), .io_in(io_in1), .env_restart(env1));

  // Model state, index 0 = dut0, 1 = dut1
  logic [7:0] mb [2][4][16];
  logic [1:0] mchip [2];
  logic [3:0] maddr [2];
  logic       mvalid [2];
  logic [7:0] mrd [2];
  logic [3:0] menv [2];
  int         nch [2] = '{2, 1};
  bit         msk [2] = '{1'b1, 1'b0};

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [7:0] model_mask(input int r, input bit m);
    if (!m) return 8'hFF;
    if (r == 1 || r == 3 || r == 5 || r == 13) return 8'h0F;
    if (r == 6 || r == 8 || r == 9 || r == 10) return 8'h1F;
    return 8'hFF;
  endfunction

  function automatic logic [15:0] pins(input int m, input int c);
    return (m == 0) ? io_in0[c*16 +: 16] : io_in1;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic a0, input logic wr, input logic rd, input logic [7:0] wd);
    logic [1:0]  nd;
    logic [15:0] p;
    int          ch, ad;
    for (int m = 0; m < 2; m++) begin
      menv[m] = '0;
      ch = int'(mchip[m]);
      ad = int'(maddr[m]);
      if (reset) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 16; r++) mb[m][c][r] = 8'h00;
        mchip[m] = 2'd0; maddr[m] = 4'd0; mvalid[m] = 1'b1; mrd[m] = 8'h00;
      end else if (wr) begin
        if (!a0) begin
          nd = ~wd[1:0];
          if (wd[7:2] == 6'h3F) begin
            if (int'(nd) < nch[m]) mchip[m] = nd;
          end else if (wd[7:4] == 4'h0) begin
            maddr[m] = wd[3:0]; mvalid[m] = 1'b1;
          end else begin
            mvalid[m] = 1'b0;
          end
        end else if (mvalid[m]) begin
          mb[m][ch][ad] = wd & model_mask(ad, msk[m]);
          if (ad == 13) menv[m][ch] = 1'b1;
        end
      end else if (rd) begin
        if (a0) begin
          p = pins(m, ch);
          if (!mvalid[m])   mrd[m] = 8'hFF;
          else if (ad == 14) mrd[m] = mb[m][ch][7][6] ? mb[m][ch][14] : p[7:0];
          else if (ad == 15) mrd[m] = mb[m][ch][7][7] ? mb[m][ch][15] : p[15:8];
          else               mrd[m] = mb[m][ch][ad];
        end else begin
          mrd[m] = {mchip[m], mvalid[m], 1'b0, maddr[m]};
        end
      end
    end
  endtask

  task automatic check_all();
    logic [255:0] er0;
    logic [127:0] er1;
    logic [31:0]  eo0;
    logic [3:0]   eoe0;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 16; r++) er0[(c*16+r)*8 +: 8] = mb[0][c][r];
      eo0[c*16 +: 16] = {mb[0][c][15], mb[0][c][14]};
      eoe0[c*2 +: 2]  = {mb[0][c][7][7], mb[0][c][7][6]};
    end
    for (int r = 0; r < 16; r++) er1[r*8 +: 8] = mb[1][0][r];
    chk("regs0", regs0, er0);
    chk("io_out0", io_out0, eo0);
    chk("io_oe0", io_oe0, eoe0);
    chk("env0", env0, menv[0][1:0]);
    chk("rdata0", bus0.rdata, mrd[0]);
    chk("regs1", regs1, er1);
    chk("io_out1", io_out1, {mb[1][0][15], mb[1][0][14]});
    chk("io_oe1", io_oe1, {mb[1][0][7][7], mb[1][0][7][6]});
    chk("env1", env1, menv[1][0]);
    chk("rdata1", bus1.rdata, mrd[1]);
  endtask

  task automatic step(input logic a0, input logic wr, input logic rd, input logic [7:0] wd);
    bus0.a0 = a0; bus0.wr_tick = wr; bus0.rd_tick = rd; bus0.wdata = wd;
    bus1.a0 = a0; bus1.wr_tick = wr; bus1.rd_tick = rd; bus1.wdata = wd;
    @(posedge clk);
    model_edge(a0, wr, rd, wd);
    #1;
    check_all();
    bus0.wr_tick = 1'b0; bus0.rd_tick = 1'b0;
    bus1.wr_tick = 1'b0; bus1.rd_tick = 1'b0;
  endtask

  task automatic wr_addr(input logic [7:0] b); step(1'b0, 1'b1, 1'b0, b); endtask
  task automatic wr_data(input logic [7:0] b); step(1'b1, 1'b1, 1'b0, b); endtask
  task automatic rd_data();                     step(1'b1, 1'b0, 1'b1, 8'h00); endtask
  task automatic rd_stat();                     step(1'b0, 1'b0, 1'b1, 8'h00); endtask
  task automatic idle();                        step(1'b0, 1'b0, 1'b0, 8'h00); endtask

  initial begin
    logic [7:0] wd;
    bus0.a0 = 1'b0; bus0.wr_tick = 1'b0; bus0.rd_tick = 1'b0; bus0.wdata = '0;
    bus1.a0 = 1'b0; bus1.wr_tick = 1'b0; bus1.rd_tick = 1'b0; bus1.wdata = '0;
    io_in0 = 32'h0; io_in1 = 16'h0;
    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;

    // Reset mid-sequence, with a colliding write/read that reset must override
    wr_addr(8'h00); wr_data(8'h21); rd_data();
    chk("t1_pre_r0", regs0[7:0], 8'h21);
    chk("t1_pre_rd", bus0.rdata, 8'h21);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 8'h99);
    reset = 1'b0;
    chk("t1_regs", regs0, 256'h0);
    chk("t1_rdata", bus0.rdata, 8'h00);
    chk("t1_env", env0, 2'b00);
    rd_stat();
    chk("t1_status", bus0.rdata, 8'h20);

    // Masking of unused bits
    wr_addr(8'h01); wr_data(8'hFF); rd_data();
    chk("t2_r1_mask", bus0.rdata, 8'h0F);
    chk("t2_r1_nomask", bus1.rdata, 8'hFF);
    wr_addr(8'h06); wr_data(8'hFF); rd_data();
    chk("t2_r6_mask", bus0.rdata, 8'h1F);
    chk("t2_r6_nomask", bus1.rdata, 8'hFF);
    wr_addr(8'h08); wr_data(8'hFF); rd_data();
    chk("t2_r8_mask", bus0.rdata, 8'h1F);
    chk("t2_r8_nomask", bus1.rdata, 8'hFF);

    // Chip select
    wr_addr(8'hFE); wr_addr(8'h00); wr_data(8'h55);
    wr_addr(8'hFF); wr_addr(8'h00); wr_data(8'hAA);
    chk("t3_chip1_r0", regs0[135:128], 8'h55);
    chk("t3_chip0_r0", regs0[7:0], 8'hAA);
    wr_addr(8'hFD); rd_stat();
    chk("t3_sel_ignored", bus0.rdata, 8'h20);

    // Envelope restart strobe on chip 1
    wr_addr(8'hFE); wr_addr(8'h0D); wr_data(8'h02);
    chk("t4_env_a", env0, 2'b10);
    idle();
    chk("t4_env_a_off", env0, 2'b00);
    wr_data(8'h02);
    chk("t4_env_b", env0, 2'b10);
    idle();
    chk("t4_env_b_off", env0, 2'b00);

    // I/O port A readback
    wr_addr(8'hFF);
    io_in0 = 32'h0000_003C; io_in1 = 16'h003C;
    wr_addr(8'h0E); wr_data(8'h81);
    wr_addr(8'h07); wr_data(8'h00);
    wr_addr(8'h0E); rd_data();
    chk("t5_pin", bus0.rdata, 8'h3C);
    chk("t5_pin1", bus1.rdata, 8'h3C);
    wr_addr(8'h07); wr_data(8'h40);
    wr_addr(8'h0E); rd_data();
    chk("t5_reg", bus0.rdata, 8'h81);
    chk("t5_reg1", bus1.rdata, 8'h81);
    chk("t5_oe", io_oe0[0], 1'b1);

    // Invalid address, then write/read collision
    wr_addr(8'h20); wr_data(8'h77); rd_data();
    chk("t6_invalid", bus0.rdata, 8'hFF);
    wr_addr(8'h00); rd_data();
    chk("t6_r0", bus0.rdata, 8'hAA);
    step(1'b1, 1'b1, 1'b1, 8'h11);
    chk("t6_hold", bus0.rdata, 8'hAA);
    chk("t6_land", regs0[7:0], 8'h11);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        io_in0 = $urandom;
        io_in1 = 16'($urandom);
      end
      case ($urandom_range(0, 3))
        0:       wd = {4'h0, 4'($urandom)};
        1:       wd = {6'h3F, 2'($urandom)};
        default: wd = 8'($urandom);
      endcase
      reset = ($urandom_range(0, 99) == 0);
      step(1'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), wd);
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
